exec_muldiv_unit: RTL and testbench
===================================

Name: exec_muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage. It consumes the ID/EX pipeline-register outputs: ALU operands, destination register and the mul/div operation select. It computes one result bit per cycle (radix-2) and raises busy_out to stall fetch/decode until the result is written back. Result, destination address and write enable are registered and go to the EX/MEM pipeline.

Parameters:
DATA_WIDTH, 32, operand and result width
REG_ADDR_WIDTH, 5, destination register address width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start_in  input  1  valid mul/div operation presented by ID/EX
op_sel_in  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
data_alu_a_in  input  DATA_WIDTH  multiplicand / dividend
data_alu_b_in  input  DATA_WIDTH  multiplier / divisor
reg_wr_addr_in  input  REG_ADDR_WIDTH  destination register
flush_in  input  1  abort current operation (branch/jump squash)
busy_out  output  1  stall request to upstream stages
done_out  output  1  one-cycle result-valid pulse
result_out  output  DATA_WIDTH  low product word or quotient
reg_wr_addr_out  output  REG_ADDR_WIDTH  destination register, captured at accept
reg_wr_en_out  output  1  register-file write enable, equal to done_out
div_by_zero_out  output  1  asserted with done_out when divisor was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all registered outputs are 0; FSM is in IDLE; bit counter is 0. Reset mid-operation discards the operation with no write.
- FSM states are IDLE, CALC, FIX and DONE. busy_out is 1 whenever the state is not IDLE; it is decoded combinationally from the state.
- Accept: start_in=1 in IDLE with flush_in=0, sampled at edge E0.
  - Operands, op_sel and reg_wr_addr are latched at E0.
  - Signed ops latch operand magnitudes plus a result-sign flag (a_sign XOR b_sign for both MULT and DIV; quotient sign only).
  - Counter loads DATA_WIDTH-1 and the state goes to CALC.
- While busy_out=1, start_in is ignored. Upstream holds its register because of the stall.
- CALC, one step per cycle:
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper accumulator half, then shift the accumulator right by 1.
  - Divide: restoring. Shift the remainder left with the next dividend bit, trial-subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
  - The counter decrements each step. At counter==0 the next state is FIX, so CALC lasts exactly DATA_WIDTH cycles.
- FIX, one cycle: two's-complement negate the low DATA_WIDTH result bits if the op is signed and the sign flag is set. Next state is DONE.
- DONE, one cycle:
  - done_out=1, reg_wr_en_out=1, result_out is valid and reg_wr_addr_out holds the latched address.
  - Next state is IDLE. done_out is high at edge E0+DATA_WIDTH+1.
  - result_out holds its value until the next DONE; done_out and reg_wr_en_out return to 0.
- Divide by zero: DIV/DIVU with b==0 at accept goes directly to DONE at E0+1.
  - result_out = all ones and div_by_zero_out=1.
  - div_by_zero_out is cleared on every other DONE.
- Signed overflow: DIV of the most-negative value by -1 yields the most-negative value. This falls out of the magnitude-and-negate algorithm; no special case is needed.
- Widths: the multiply accumulator is 2*DATA_WIDTH and only the low DATA_WIDTH bits are output. The remainder register is DATA_WIDTH+1 bits.
- Flush:
  - flush_in=1 in any non-IDLE state returns the FSM to IDLE at the next edge, with no done_out and no write.
  - flush_in and start_in together in IDLE: flush wins and nothing is accepted.
  - flush_in in DONE suppresses done_out and reg_wr_en_out for that cycle.
- Reset has priority over flush, and flush has priority over start.

Decomposition:
- The shared package dlx_pkg holds:
  - op_sel encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - FSM state encodings;
  - the mapping from decode function codes to op_sel.
- One sub-module is natural: muldiv_step. It is combinational and computes a single shift-add or restore-subtract iteration on the accumulator/remainder. The top level owns the FSM, counter, sign handling and output registers.

Test Plan:
- MULTU a=7, b=6, accepted at E0 -> done_out at E0+33, result_out=42, reg_wr_en_out=1, busy_out high E0+1..E0+33.
- MULT a=0xFFFFFFFD (-3), b=5 -> result_out=0xFFFFFFF1; also a=0x0001_0000, b=0x0001_0000 -> result_out=0 (low word).
- DIV a=0xFFFFFFF9 (-7), b=2 -> result_out=0xFFFFFFFD (-3, truncation toward zero); DIVU a=100, b=7 -> 14.
- DIVU a=5, b=0 -> done_out at E0+1, result_out=0xFFFFFFFF, div_by_zero_out=1; a following DIVU 9/3 -> 3, div_by_zero_out=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> result_out=0x80000000, no div_by_zero.
- flush_in pulsed 10 cycles after accept -> busy_out low next cycle, no done_out. rst asserted mid-CALC -> all outputs 0 next edge. start_in held during busy -> accepted only once.

Source files
------------

// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_pkg
// Description : Shared encodings for the DLX execute-stage mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MULT  = 6'h0e;
    localparam logic [5:0] FUNCT_MULTU = 6'h16;
    localparam logic [5:0] FUNCT_DIV   = 6'h0f;
    localparam logic [5:0] FUNCT_DIVU  = 6'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Decode-stage helper: R-type function code to mul/div operation select.
    function automatic logic [1:0] funct_to_op_sel(input logic [5:0] funct);
        logic [1:0] op;
        case (funct)
            FUNCT_MULTU: op = OP_MULTU;
            FUNCT_DIV:   op = OP_DIV;
            FUNCT_DIVU:  op = OP_DIVU;
            default:     op = OP_MULT;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc_in,
    input  logic [DATA_WIDTH:0]       rem_in,
    input  logic [DATA_WIDTH-1:0]     opnd_in,
    output logic [2*DATA_WIDTH-1:0]   acc_out,
    output logic [DATA_WIDTH:0]       rem_out
);

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_q_bit;

    always_comb begin
        w_sum   = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (acc_in[0] ? {1'b0, opnd_in} : '0);
        // Remainder shifted left with the next dividend bit (held in acc MSB of low half).
        w_shift = {rem_in, acc_in[DATA_WIDTH-1]};
        w_diff  = w_shift - {2'b00, opnd_in};
        w_q_bit = ~w_diff[DATA_WIDTH+1];

        acc_out = {w_sum, acc_in[DATA_WIDTH-1:1]};
        rem_out = rem_in;
        if (is_div) begin
            acc_out = {acc_in[2*DATA_WIDTH-1:DATA_WIDTH], acc_in[DATA_WIDTH-2:0], w_q_bit};
            rem_out = w_q_bit ? w_diff[DATA_WIDTH:0] : w_shift[DATA_WIDTH:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv_unit
// Description : Iterative radix-2 multiply/divide unit for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_muldiv_unit
    import dlx_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_in,
    input  logic [1:0]                op_sel_in,
    input  logic [DATA_WIDTH-1:0]     data_alu_a_in,
    input  logic [DATA_WIDTH-1:0]     data_alu_b_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    input  logic                      flush_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      reg_wr_en_out,
    output logic                      div_by_zero_out
);

    localparam int              CNT_W      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(DATA_WIDTH - 1);

    muldiv_state_t              r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [2*DATA_WIDTH-1:0]    r_acc;
    logic [DATA_WIDTH:0]        r_rem;
    logic [DATA_WIDTH-1:0]      r_opnd;
    logic                       r_is_div;
    logic                       r_neg;
    logic                       r_dbz_pend;

    logic                       w_signed;
    logic                       w_is_div;
    logic                       w_a_neg;
    logic                       w_b_neg;
    logic [DATA_WIDTH-1:0]      w_a_mag;
    logic [DATA_WIDTH-1:0]      w_b_mag;
    logic [2*DATA_WIDTH-1:0]    w_acc_next;
    logic [DATA_WIDTH:0]        w_rem_next;
    logic [DATA_WIDTH-1:0]      w_res_lo;

    always_comb begin
        w_signed = (op_sel_in == OP_MULT) || (op_sel_in == OP_DIV);
        w_is_div = (op_sel_in == OP_DIV) || (op_sel_in == OP_DIVU);
        w_a_neg  = w_signed & data_alu_a_in[DATA_WIDTH-1];
        w_b_neg  = w_signed & data_alu_b_in[DATA_WIDTH-1];
        w_a_mag  = w_a_neg ? (~data_alu_a_in + 1'b1) : data_alu_a_in;
        w_b_mag  = w_b_neg ? (~data_alu_b_in + 1'b1) : data_alu_b_in;
        w_res_lo = r_acc[DATA_WIDTH-1:0];
    end

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .is_div  (r_is_div),
        .acc_in  (r_acc),
        .rem_in  (r_rem),
        .opnd_in (r_opnd),
        .acc_out (w_acc_next),
        .rem_out (w_rem_next)
    );

    assign busy_out      = (r_state != ST_IDLE);
    assign done_out      = (r_state == ST_DONE) && !flush_in;
    assign reg_wr_en_out = done_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_acc           <= '0;
            r_rem           <= '0;
            r_opnd          <= '0;
            r_is_div        <= 1'b0;
            r_neg           <= 1'b0;
            r_dbz_pend      <= 1'b0;
            result_out      <= '0;
            reg_wr_addr_out <= '0;
            div_by_zero_out <= 1'b0;
        end else if (flush_in) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        reg_wr_addr_out <= reg_wr_addr_in;
                        r_is_div        <= w_is_div;
                        r_neg           <= w_a_neg ^ w_b_neg;
                        r_rem           <= '0;
                        r_cnt           <= C_CNT_INIT;
                        // Multiplicand or divisor stays in r_opnd; multiplier or dividend shifts through r_acc.
                        if (w_is_div) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{DATA_WIDTH{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{DATA_WIDTH{1'b0}}, w_b_mag};
                        end
                        if (w_is_div && (data_alu_b_in == '0)) begin
                            r_dbz_pend <= 1'b1;
                            r_state    <= ST_FIX;
                        end else begin
                            r_dbz_pend <= 1'b0;
                            r_state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_dbz_pend) begin
                        result_out      <= '1;
                        div_by_zero_out <= 1'b1;
                    end else begin
                        result_out      <= r_neg ? (~w_res_lo + 1'b1) : w_res_lo;
                        div_by_zero_out <= 1'b0;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_muldiv_unit
// Description : Directed self-checking bench for exec_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_muldiv_unit;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    logic                      clk;
    logic                      rst;
    logic                      start_in;
    logic [1:0]                op_sel_in;
    logic [DATA_WIDTH-1:0]     data_alu_a_in;
    logic [DATA_WIDTH-1:0]     data_alu_b_in;
    logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in;
    logic                      flush_in;
    logic                      busy_out;
    logic                      done_out;
    logic [DATA_WIDTH-1:0]     result_out;
    logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out;
    logic                      reg_wr_en_out;
    logic                      div_by_zero_out;

    int r_vec_cnt;
    int r_err_cnt;

    exec_muldiv_unit #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .op_sel_in       (op_sel_in),
        .data_alu_a_in   (data_alu_a_in),
        .data_alu_b_in   (data_alu_b_in),
        .reg_wr_addr_in  (reg_wr_addr_in),
        .flush_in        (flush_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .result_out      (result_out),
        .reg_wr_addr_out (reg_wr_addr_out),
        .reg_wr_en_out   (reg_wr_en_out),
        .div_by_zero_out (div_by_zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        r_vec_cnt++;
        if (observed !== expected) begin
            r_err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents the op for one accepting edge (E0), returns with inputs idle, #1 after E0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] addr, input bit hold_start);
        @(negedge clk);
        start_in       = 1'b1;
        op_sel_in      = op;
        data_alu_a_in  = a;
        data_alu_b_in  = b;
        reg_wr_addr_in = addr;
        @(posedge clk);
        #1;
        if (!hold_start) start_in = 1'b0;
    endtask

    // Counts edges after E0 until done_out; the count is the latency (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] addr,
                          input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat;
        issue(op, a, b, addr, 1'b0);
        check_value({tag, "_busy_e1"}, {31'b0, busy_out}, 32'd1);
        wait_done(lat);
        check_value({tag, "_latency"}, lat, exp_lat);
        check_value({tag, "_result"}, result_out, exp_res);
        check_value({tag, "_dbz"}, {31'b0, div_by_zero_out}, {31'b0, exp_dbz});
        check_value({tag, "_wr_en"}, {31'b0, reg_wr_en_out}, 32'd1);
        check_value({tag, "_wr_addr"}, {27'b0, reg_wr_addr_out}, {27'b0, addr});
        check_value({tag, "_busy_done"}, {31'b0, busy_out}, 32'd1);
        @(posedge clk);
        #1;
        check_value({tag, "_done_clr"}, {31'b0, done_out}, 32'd0);
        check_value({tag, "_busy_clr"}, {31'b0, busy_out}, 32'd0);
        check_value({tag, "_result_hold"}, result_out, exp_res);
    endtask

    initial begin
        int lat;
        int n_done;
        r_vec_cnt      = 0;
        r_err_cnt      = 0;
        rst            = 1'b1;
        start_in       = 1'b0;
        op_sel_in      = 2'b00;
        data_alu_a_in  = '0;
        data_alu_b_in  = '0;
        reg_wr_addr_in = '0;
        flush_in       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_busy", {31'b0, busy_out}, 32'd0);
        check_value("rst_done", {31'b0, done_out}, 32'd0);
        check_value("rst_result", result_out, 32'd0);
        check_value("rst_addr", {27'b0, reg_wr_addr_out}, 32'd0);
        check_value("rst_dbz", {31'b0, div_by_zero_out}, 32'd0);
        rst = 1'b0;

        run_op("multu_7x6",   2'b01, 32'd7,         32'd6,         5'd3,  32'd42,         1'b0, 33);
        run_op("mult_m3x5",   2'b00, 32'hFFFFFFFD,  32'd5,         5'd4,  32'hFFFFFFF1,   1'b0, 33);
        run_op("mult_lowword",2'b00, 32'h00010000,  32'h00010000,  5'd5,  32'd0,          1'b0, 33);
        run_op("div_m7d2",    2'b10, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFD,   1'b0, 33);
        run_op("divu_100d7",  2'b11, 32'd100,       32'd7,         5'd7,  32'd14,         1'b0, 33);
        run_op("divu_by0",    2'b11, 32'd5,         32'd0,         5'd8,  32'hFFFFFFFF,   1'b1, 1);
        run_op("divu_9d3",    2'b11, 32'd9,         32'd3,         5'd9,  32'd3,          1'b0, 33);
        run_op("div_ovf",     2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd10, 32'h80000000,   1'b0, 33);
        run_op("mult_m4xm6",  2'b00, 32'hFFFFFFFC,  32'hFFFFFFFA,  5'd11, 32'd24,         1'b0, 33);

        // Flush ten cycles into CALC: unit drops back to idle and never writes.
        issue(2'b01, 32'd11, 32'd13, 5'd12, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        check_value("flush_busy", {31'b0, busy_out}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_out || reg_wr_en_out) n_done++;
        end
        check_value("flush_no_done", n_done, 0);
        check_value("flush_result_kept", result_out, 32'd24);

        // Flush together with start in idle: nothing is accepted.
        @(negedge clk);
        start_in = 1'b1;
        flush_in = 1'b1;
        op_sel_in = 2'b01;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        flush_in = 1'b0;
        check_value("flush_start_idle", {31'b0, busy_out}, 32'd0);

        // Flush during DONE masks the write strobe that cycle.
        issue(2'b01, 32'd3, 32'd3, 5'd13, 1'b0);
        wait_done(lat);
        check_value("fdone_latency", lat, 33);
        flush_in = 1'b1;
        #1;
        check_value("fdone_done", {31'b0, done_out}, 32'd0);
        check_value("fdone_wr_en", {31'b0, reg_wr_en_out}, 32'd0);
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        check_value("fdone_idle", {31'b0, busy_out}, 32'd0);

        // start_in held high through the whole operation: exactly one accept.
        issue(2'b01, 32'd2, 32'd3, 5'd14, 1'b1);
        wait_done(lat);
        start_in = 1'b0;
        check_value("hold_latency", lat, 33);
        check_value("hold_result", result_out, 32'd6);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_out || busy_out) n_done++;
        end
        check_value("hold_single_accept", n_done, 0);

        // Reset mid-CALC clears all registered outputs with no write.
        run_op("pre_rst", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1'b0, 33);
        run_op("pre_rst_dbz", 2'b10, 32'd1, 32'd0, 5'd22, 32'hFFFFFFFF, 1'b1, 1);
        issue(2'b01, 32'd9, 32'd9, 5'd23, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("midrst_busy", {31'b0, busy_out}, 32'd0);
        check_value("midrst_done", {31'b0, done_out}, 32'd0);
        check_value("midrst_result", result_out, 32'd0);
        check_value("midrst_addr", {27'b0, reg_wr_addr_out}, 32'd0);
        check_value("midrst_dbz", {31'b0, div_by_zero_out}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_out) n_done++;
        end
        check_value("midrst_no_done", n_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", r_vec_cnt, r_err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
